bitreverse_vsz: RTL and testbench

- Runtime-variable-size bit-reversal reorder buffer for the pipelined FFT output path.
- Generalised successor of the fixed-size single-word reorderer:
  - frame size selectable per frame, from 2^LGMIN to 2^LGMAX;
  - frames aligned to an input sync strobe;
  - misalignment detected, flagged and recovered from.
- Sits between the last FFT stage and the downstream consumer; ping-pong RAM, one sample in and one out per i_ce.

---
 rtl/bitreverse_vsz_pkg.sv | 18 +
 rtl/bitreverse_vsz_bitrev_index.sv | 26 ++
 rtl/bitreverse_vsz.sv | 156 +++++++++++++++
 tb/tb_bitreverse_vsz.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/bitreverse_vsz_pkg.sv
// Shared definitions for the FFT output reorder blocks: controller states and
// the frame-size clamp.
package bitreverse_vsz_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_FILL = 2'd1,
    ST_RUN  = 2'd2
  } state_e;

  // Limit a requested log2 frame size to the supported range.
  function automatic int unsigned clamp_lg(int unsigned lg, int unsigned lo, int unsigned hi);
    if (lg < lo) return lo;
    if (lg > hi) return hi;
    return lg;
  endfunction

endpackage

// File: rtl/bitreverse_vsz_bitrev_index.sv
// Combinational bit-reversed index: reverses the low lg_i bits of k_i and
// zeroes everything above them.
module bitreverse_vsz_bitrev_index #(
  parameter int unsigned LGMAX = 10,
  parameter int unsigned LGW   = 4
) (
  input  logic [LGMAX-1:0] k_i,
  input  logic [LGW-1:0]   lg_i,
  output logic [LGMAX-1:0] rev_o
);

  logic [LGMAX-1:0] rev_full_c;
  logic [LGW-1:0]   shift_c;

  // Full-width reversal, then shift the wanted field down to bit 0.
  always_comb begin
    rev_full_c = '0;
    for (int j = 0; j < int'(LGMAX); j++) begin
      rev_full_c[j] = k_i[int'(LGMAX) - 1 - j];
    end
  end

  assign shift_c = LGW'(LGMAX) - lg_i;
  assign rev_o   = rev_full_c >> shift_c;

endmodule

// File: rtl/bitreverse_vsz.sv
// Runtime-variable-size bit-reversal reorder buffer: ping-pong RAM, frames
// aligned to i_sync, misaligned syncs flagged on o_err and resynchronised.
module bitreverse_vsz
  import bitreverse_vsz_pkg::*;
#(
  parameter int unsigned LGMAX = 10,
  parameter int unsigned LGMIN = 2,
  parameter int unsigned LGW   = 4,
  parameter int unsigned WIDTH = 24
) (
  input  logic                 i_clk,
  input  logic                 i_reset,
  input  logic                 i_ce,
  input  logic                 i_sync,
  input  logic [LGW-1:0]       i_lgsize,
  input  logic [2*WIDTH-1:0]   i_in,
  output logic [2*WIDTH-1:0]   o_out,
  output logic                 o_sync,
  output logic                 o_err,
  output logic [LGW-1:0]       o_lgsize
);

  localparam int unsigned DW    = 2 * WIDTH;
  localparam int unsigned AW    = LGMAX + 1;
  localparam int unsigned DEPTH = 1 << AW;

  state_e           state_q, state_d;
  logic [LGMAX-1:0] k_q, k_d;
  logic             b_q, b_d;
  logic [LGW-1:0]   lwr_q, lwr_d;
  logic [LGW-1:0]   lrd_q, lrd_d;
  logic [DW-1:0]    out_q, out_d;
  logic             sync_q, sync_d;
  logic             err_q, err_d;
  logic [LGW-1:0]   lgsize_q, lgsize_d;

  logic [DW-1:0]    mem [DEPTH];

  logic [LGW-1:0]   lg_clamp_c;
  logic [LGMAX-1:0] last_k_c;
  logic [LGMAX-1:0] rev_c;
  logic             we_c;
  logic [LGMAX-1:0] wk_c;
  logic [AW-1:0]    waddr_c;
  logic [AW-1:0]    raddr_c;
  logic [DW-1:0]    rdata_c;

  assign lg_clamp_c = LGW'(clamp_lg(32'(i_lgsize), LGMIN, LGMAX));
  assign last_k_c   = {LGMAX{1'b1}} >> (LGW'(LGMAX) - lwr_q);

  bitreverse_vsz_bitrev_index #(
    .LGMAX (LGMAX),
    .LGW   (LGW)
  ) u_rev (
    .k_i   (k_q),
    .lg_i  (lrd_q),
    .rev_o (rev_c)
  );

  // The write bank and read bank always differ, so no read/write collision.
  assign waddr_c = {b_q, wk_c};
  assign raddr_c = {~b_q, rev_c};
  assign rdata_c = mem[raddr_c];

  always_ff @(posedge i_clk) begin
    if (we_c && !i_reset) mem[waddr_c] <= i_in;
  end

  always_comb begin
    state_d  = state_q;
    k_d      = k_q;
    b_d      = b_q;
    lwr_d    = lwr_q;
    lrd_d    = lrd_q;
    out_d    = out_q;
    sync_d   = sync_q;
    err_d    = 1'b0;
    lgsize_d = lgsize_q;
    we_c     = 1'b0;
    wk_c     = k_q;

    if (i_ce) begin
      case (state_q)
        ST_IDLE: begin
          if (i_sync) begin
            we_c    = 1'b1;
            wk_c    = '0;
            k_d     = LGMAX'(1);
            lwr_d   = lg_clamp_c;
            state_d = ST_FILL;
          end
        end
        ST_FILL, ST_RUN: begin
          we_c = 1'b1;
          if (i_sync && (k_q != '0)) begin
            // Sync arrived mid-frame: restart the frame on this sample.
            err_d   = 1'b1;
            wk_c    = '0;
            k_d     = LGMAX'(1);
            lwr_d   = lg_clamp_c;
            sync_d  = 1'b0;
            state_d = ST_FILL;
          end else begin
            if (k_q == '0) lwr_d = lg_clamp_c;
            if (k_q == last_k_c) begin
              k_d      = '0;
              b_d      = ~b_q;
              lrd_d    = lwr_q;
              lgsize_d = lwr_q;
              state_d  = ST_RUN;
            end else begin
              k_d = k_q + LGMAX'(1);
            end
            if (state_q == ST_RUN) begin
              out_d  = rdata_c;
              sync_d = (k_q == '0);
            end else begin
              sync_d = 1'b0;
            end
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q  <= ST_IDLE;
      k_q      <= '0;
      b_q      <= 1'b0;
      lwr_q    <= LGW'(LGMAX);
      lrd_q    <= LGW'(LGMAX);
      out_q    <= '0;
      sync_q   <= 1'b0;
      err_q    <= 1'b0;
      lgsize_q <= LGW'(LGMAX);
    end else begin
      state_q  <= state_d;
      k_q      <= k_d;
      b_q      <= b_d;
      lwr_q    <= lwr_d;
      lrd_q    <= lrd_d;
      out_q    <= out_d;
      sync_q   <= sync_d;
      err_q    <= err_d;
      lgsize_q <= lgsize_d;
    end
  end

  assign o_out    = out_q;
  assign o_sync   = sync_q;
  assign o_err    = err_q;
  assign o_lgsize = lgsize_q;

endmodule

// File: tb/tb_bitreverse_vsz.sv
// Self-checking bench for bitreverse_vsz: vector table plus scoreboard queue.
module tb_bitreverse_vsz;

  localparam int unsigned LGMAX = 4;
  localparam int unsigned LGMIN = 2;
  localparam int unsigned LGW   = 4;
  localparam int unsigned WIDTH = 8;
  localparam int unsigned DW    = 2 * WIDTH;

  logic           i_clk = 1'b0;
  logic           i_reset;
  logic           i_ce;
  logic           i_sync;
  logic [LGW-1:0] i_lgsize;
  logic [DW-1:0]  i_in;
  logic [DW-1:0]  o_out;
  logic           o_sync;
  logic           o_err;
  logic [LGW-1:0] o_lgsize;

  bitreverse_vsz #(
    .LGMAX (LGMAX),
    .LGMIN (LGMIN),
    .LGW   (LGW),
    .WIDTH (WIDTH)
  ) dut (
    .i_clk    (i_clk),
    .i_reset  (i_reset),
    .i_ce     (i_ce),
    .i_sync   (i_sync),
    .i_lgsize (i_lgsize),
    .i_in     (i_in),
    .o_out    (o_out),
    .o_sync   (o_sync),
    .o_err    (o_err),
    .o_lgsize (o_lgsize)
  );

  always #5 i_clk = ~i_clk;

  typedef struct {
    logic           sync;
    logic [LGW-1:0] lg;
    logic [DW-1:0]  din;
    logic           chk_out;
    logic [DW-1:0]  eout;
    logic           esync;
    logic           eerr;
    logic           chk_lg;
    logic [LGW-1:0] elg;
  } vec_t;

  vec_t vecs[$];
  vec_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   vidx   = 0;
  int   exp8[8] = '{0, 4, 2, 6, 1, 5, 3, 7};
  int   exp4[4] = '{0, 2, 1, 3};

  function automatic int rev(int j, int l);
    int r = 0;
    for (int i = 0; i < l; i++) begin
      if (((j >> (l - 1 - i)) & 1) != 0) r |= (1 << i);
    end
    return r;
  endfunction

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic void add(logic s, int lg, int din, logic chk, int eout,
                              logic es, logic ee, logic cl, int elg);
    vec_t v;
    v.sync    = s;
    v.lg      = LGW'(lg);
    v.din     = DW'(din);
    v.chk_out = chk;
    v.eout    = DW'(eout);
    v.esync   = es;
    v.eerr    = ee;
    v.chk_lg  = cl;
    v.elg     = LGW'(elg);
    vecs.push_back(v);
  endfunction

  // mode 0: output don't-care, 1: output must still be 0, 2: reversed frame.
  function automatic void add_frame(int base, int lg, int n, logic s0, int mode,
                                    int ebase, int el, int elg);
    for (int j = 0; j < n; j++) begin
      logic chk;
      chk = (mode == 1) || ((mode == 2) && (j < (1 << el)));
      add(s0 && (j == 0), lg, base + j, chk, (mode == 1) ? 0 : ebase + rev(j, el),
          (mode == 2) && (j == 0), 1'b0, j == 0, elg);
    end
  endfunction

  task automatic run_vecs(int gap);
    vec_t v;
    vec_t e;
    while (vecs.size() > 0) begin
      v = vecs.pop_front();
      @(negedge i_clk);
      i_ce     = 1'b1;
      i_sync   = v.sync;
      i_lgsize = v.lg;
      i_in     = v.din;
      sb.push_back(v);
      @(posedge i_clk);
      #1;
      e = sb.pop_front();
      if (e.chk_out) check($sformatf("out[%0d]", vidx), 32'(o_out), 32'(e.eout));
      check($sformatf("sync[%0d]", vidx), 32'(o_sync), 32'(e.esync));
      check($sformatf("err[%0d]", vidx), 32'(o_err), 32'(e.eerr));
      if (e.chk_lg) check($sformatf("lgsize[%0d]", vidx), 32'(o_lgsize), 32'(e.elg));
      for (int g = 0; g < gap; g++) begin
        @(negedge i_clk);
        i_ce     = 1'b0;
        i_sync   = 1'($urandom);
        i_in     = DW'($urandom);
        i_lgsize = LGW'($urandom);
        @(posedge i_clk);
        #1;
        if (e.chk_out) check($sformatf("hold_out[%0d]", vidx), 32'(o_out), 32'(e.eout));
        check($sformatf("hold_sync[%0d]", vidx), 32'(o_sync), 32'(e.esync));
        check($sformatf("hold_err[%0d]", vidx), 32'(o_err), 32'd0);
      end
      vidx++;
    end
    @(negedge i_clk);
    i_ce   = 1'b0;
    i_sync = 1'b0;
  endtask

  task automatic do_reset(string tag);
    @(negedge i_clk);
    i_reset = 1'b1;
    i_ce    = 1'b1;
    i_sync  = 1'b1;
    i_in    = DW'(16'hbeef);
    @(posedge i_clk);
    #1;
    check({tag, "_rst_out"}, 32'(o_out), 32'd0);
    check({tag, "_rst_sync"}, 32'(o_sync), 32'd0);
    check({tag, "_rst_err"}, 32'(o_err), 32'd0);
    check({tag, "_rst_lgsize"}, 32'(o_lgsize), 32'(LGMAX));
    @(negedge i_clk);
    i_reset = 1'b0;
    i_ce    = 1'b0;
    i_sync  = 1'b0;
  endtask

  initial begin
    i_reset  = 1'b1;
    i_ce     = 1'b0;
    i_sync   = 1'b0;
    i_lgsize = LGW'(3);
    i_in     = '0;
    repeat (3) @(posedge i_clk);
    do_reset("init");

    // Size 3 frames, then 3->4, 4->3 switches and a free-running frame.
    add_frame(0, 3, 8, 1'b1, 1, 0, 3, LGMAX);
    for (int j = 0; j < 8; j++) add(j == 0, 3, 8 + j, 1'b1, exp8[j], j == 0, 1'b0, j == 0, 3);
    add_frame(16, 4, 16, 1'b1, 2, 8, 3, 3);
    add_frame(32, 4, 16, 1'b1, 2, 16, 4, 4);
    add_frame(48, 3, 8, 1'b1, 2, 32, 4, 4);
    add_frame(56, 3, 8, 1'b1, 2, 48, 3, 3);
    add_frame(64, 3, 8, 1'b0, 2, 56, 3, 3);
    run_vecs(0);

    // Reset in the middle of RUN, then the size-3 case at 1-in-3 strobe duty.
    do_reset("midrun");
    add(1'b0, 3, 100, 1'b1, 0, 1'b0, 1'b0, 1'b1, LGMAX);
    add(1'b0, 3, 101, 1'b1, 0, 1'b0, 1'b0, 1'b0, 0);
    add_frame(0, 3, 8, 1'b1, 1, 0, 3, LGMAX);
    for (int j = 0; j < 8; j++) add(j == 0, 3, 8 + j, 1'b1, exp8[j], j == 0, 1'b0, j == 0, 3);
    run_vecs(2);

    // Sync injected at k=5: error pulse, one silent frame, then recovery.
    add_frame(16, 3, 5, 1'b1, 2, 8, 3, 3);
    add(1'b1, 3, 21, 1'b0, 0, 1'b0, 1'b1, 1'b1, 3);
    add_frame(22, 3, 7, 1'b0, 0, 0, 3, 3);
    add_frame(29, 3, 8, 1'b1, 2, 21, 3, 3);
    add_frame(37, 3, 8, 1'b1, 2, 29, 3, 3);
    run_vecs(0);

    // Size clamping: 1 acts as 2, 15 acts as 4.
    do_reset("clamp");
    add_frame(0, 1, 4, 1'b1, 1, 0, 2, LGMAX);
    for (int j = 0; j < 4; j++) add(j == 0, 1, 4 + j, 1'b1, exp4[j], j == 0, 1'b0, j == 0, 2);
    add_frame(8, 15, 16, 1'b1, 2, 4, 2, 2);
    add_frame(24, 2, 4, 1'b1, 2, 8, 4, 4);
    add_frame(28, 2, 4, 1'b1, 2, 24, 2, 2);
    run_vecs(0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
